// File: rtl/cpu_pkg.sv
// Shared types for the EX/MEM pipeline slice: datapath widths, the held-entry
// record and the occupancy state of the EX/MEM holding stage.
package cpu_pkg;

    localparam int DW = 32;
    localparam int RW = 5;

    typedef struct packed {
        logic [DW-1:0] alu_out;
        logic [DW-1:0] store_data;
        logic [DW-1:0] target;
        logic [RW-1:0] rd;
        logic          zf;
        logic          reg_write;
        logic          mem_read;
        logic          mem_write;
        logic          mem_to_reg;
        logic          branch;
    } ex_mem_entry_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } ex_mem_state_t;

endpackage

// File: rtl/ex_mem_entry_reg.sv
// One EX/MEM entry register with load enable and synchronous clear.
module ex_mem_entry_reg
    import cpu_pkg::*;
(
    input  logic          clk,
    input  logic          clr,
    input  logic          load,
    input  ex_mem_entry_t d,
    output ex_mem_entry_t q
);

    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM holding stage: captures ALU results, resolves branches, forwards to operand select.
// EX_MEM_SKID_EN adds a skid entry and a registered ex_ready; otherwise head only.
//
// state    | meaning
// ST_EMPTY | no entry held
// ST_ONE   | head entry valid
// ST_TWO   | head and skid valid (skid build only)
module ex_mem_stage #(
    parameter int DW = cpu_pkg::DW,
    parameter int RW = cpu_pkg::RW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ex_valid,
    output logic          ex_ready,
    input  logic [DW-1:0] alu_out,
    input  logic          alu_zf,
    input  logic [DW-1:0] store_data,
    input  logic [RW-1:0] rd,
    input  logic          reg_write,
    input  logic          mem_read,
    input  logic          mem_write,
    input  logic          mem_to_reg,
    input  logic          branch,
    input  logic [DW-1:0] pc_plus4,
    input  logic [DW-1:0] branch_offset,
    input  logic          flush,
    output logic          mem_valid,
    input  logic          mem_ready,
    output logic [DW-1:0] mem_alu_out,
    output logic [DW-1:0] mem_store_data,
    output logic [RW-1:0] mem_rd,
    output logic          mem_reg_write,
    output logic          mem_mem_read,
    output logic          mem_mem_write,
    output logic          mem_mem_to_reg,
    output logic          branch_taken,
    output logic [DW-1:0] branch_target,
    output logic          fwd_en,
    output logic [RW-1:0] fwd_rd,
    output logic [DW-1:0] fwd_value
);

    cpu_pkg::ex_mem_state_t state, state_next;
    cpu_pkg::ex_mem_entry_t in_entry, head, head_d;
    logic cap, xfer, head_load;

    assign cap  = ex_valid & ex_ready;
    assign xfer = mem_valid & mem_ready;

    always_comb begin
        in_entry            = '0;
        in_entry.alu_out    = alu_out;
        in_entry.store_data = store_data;
        in_entry.target     = pc_plus4 + branch_offset;
        in_entry.rd         = rd;
        in_entry.zf         = alu_zf;
        in_entry.reg_write  = reg_write;
        in_entry.mem_read   = mem_read;
        in_entry.mem_write  = mem_write;
        in_entry.mem_to_reg = mem_to_reg;
        in_entry.branch     = branch;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= cpu_pkg::ST_EMPTY;
        end else begin
            state <= state_next;
        end
    end

`ifdef EX_MEM_SKID_EN
    cpu_pkg::ex_mem_entry_t skid;
    logic ready_q, skid_load, head_from_skid;

    assign ex_ready = ready_q;
    assign head_d   = head_from_skid ? skid : in_entry;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ready_q <= 1'b1;
        end else begin
            ready_q <= (state_next != cpu_pkg::ST_TWO);
        end
    end

    always_comb begin
        state_next     = state;
        head_load      = 1'b0;
        skid_load      = 1'b0;
        head_from_skid = 1'b0;
        if (flush) begin
            state_next = cpu_pkg::ST_EMPTY;
        end else begin
            case (state)
                cpu_pkg::ST_EMPTY: begin
                    if (cap) begin
                        head_load  = 1'b1;
                        state_next = cpu_pkg::ST_ONE;
                    end
                end
                cpu_pkg::ST_ONE: begin
                    if (cap && xfer) begin
                        head_load = 1'b1;
                    end else if (cap) begin
                        skid_load  = 1'b1;
                        state_next = cpu_pkg::ST_TWO;
                    end else if (xfer) begin
                        state_next = cpu_pkg::ST_EMPTY;
                    end
                end
                cpu_pkg::ST_TWO: begin
                    if (xfer) begin
                        head_load      = 1'b1;
                        head_from_skid = 1'b1;
                        state_next     = cpu_pkg::ST_ONE;
                    end
                end
                default: state_next = cpu_pkg::ST_EMPTY;
            endcase
        end
    end

    ex_mem_entry_reg u_skid (
        .clk  (clk),
        .clr  (!rst_n),
        .load (skid_load),
        .d    (in_entry),
        .q    (skid)
    );
`else
    // Head-only build keeps full throughput by accepting when the head drains this cycle.
    assign ex_ready = !mem_valid | mem_ready;
    assign head_d   = in_entry;

    always_comb begin
        state_next = state;
        head_load  = 1'b0;
        if (flush) begin
            state_next = cpu_pkg::ST_EMPTY;
        end else if (cap) begin
            head_load  = 1'b1;
            state_next = cpu_pkg::ST_ONE;
        end else if (xfer) begin
            state_next = cpu_pkg::ST_EMPTY;
        end
    end
`endif

    ex_mem_entry_reg u_head (
        .clk  (clk),
        .clr  (!rst_n),
        .load (head_load),
        .d    (head_d),
        .q    (head)
    );

    assign mem_valid      = (state != cpu_pkg::ST_EMPTY);
    assign mem_alu_out    = head.alu_out;
    assign mem_store_data = head.store_data;
    assign mem_rd         = head.rd;
    assign mem_reg_write  = head.reg_write;
    assign mem_mem_read   = head.mem_read;
    assign mem_mem_write  = head.mem_write;
    assign mem_mem_to_reg = head.mem_to_reg;
    assign branch_taken   = mem_valid & head.branch & head.zf;
    assign branch_target  = head.target;
    assign fwd_en         = mem_valid & head.reg_write & (head.rd != '0) & ~head.mem_read;
    assign fwd_rd         = head.rd;
    assign fwd_value      = head.alu_out;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed cases plus random traffic
// against a queue-based model of the holding stage.
module tb_ex_mem_stage;

    localparam int DW = 32;
    localparam int RW = 5;
`ifdef EX_MEM_SKID_EN
    localparam int  CAP  = 2;
    localparam bit  SKID = 1'b1;
`else
    localparam int  CAP  = 1;
    localparam bit  SKID = 1'b0;
`endif

    typedef struct packed {
        logic [DW-1:0] alu;
        logic [DW-1:0] sd;
        logic [DW-1:0] tgt;
        logic [RW-1:0] rd;
        logic          zf;
        logic          rw;
        logic          mr;
        logic          mw;
        logic          m2r;
        logic          br;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ex_valid = 1'b0;
    logic          ex_ready;
    logic [DW-1:0] alu_out = '0;
    logic          alu_zf = 1'b0;
    logic [DW-1:0] store_data = '0;
    logic [RW-1:0] rd = '0;
    logic          reg_write = 1'b0, mem_read = 1'b0, mem_write = 1'b0;
    logic          mem_to_reg = 1'b0, branch = 1'b0;
    logic [DW-1:0] pc_plus4 = '0, branch_offset = '0;
    logic          flush = 1'b0;
    logic          mem_valid;
    logic          mem_ready = 1'b0;
    logic [DW-1:0] mem_alu_out, mem_store_data, branch_target, fwd_value;
    logic [RW-1:0] mem_rd, fwd_rd;
    logic          mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg;
    logic          branch_taken, fwd_en;

    ex_mem_stage dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .alu_out(alu_out), .alu_zf(alu_zf), .store_data(store_data), .rd(rd),
        .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .mem_to_reg(mem_to_reg), .branch(branch), .pc_plus4(pc_plus4),
        .branch_offset(branch_offset), .flush(flush), .mem_valid(mem_valid),
        .mem_ready(mem_ready), .mem_alu_out(mem_alu_out), .mem_store_data(mem_store_data),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
        .mem_mem_write(mem_mem_write), .mem_mem_to_reg(mem_mem_to_reg),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .fwd_en(fwd_en), .fwd_rd(fwd_rd), .fwd_value(fwd_value)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   failures = 0;
    ent_t q[$];
    ent_t last = '0;
    bit   m_ready = 1'b1;
    bit   hold = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Offer an upstream entry; while the previous offer is stalled it is kept unchanged.
    task automatic put(input bit v, input logic [DW-1:0] a, input logic [RW-1:0] r,
                       input bit w, input bit mrd, input bit b, input bit z,
                       input logic [DW-1:0] pc, input logic [DW-1:0] off);
        if (!hold) begin
            ex_valid = v; alu_out = a; rd = r; reg_write = w; mem_read = mrd;
            branch = b; alu_zf = z; pc_plus4 = pc; branch_offset = off;
            store_data = $urandom; mem_write = 1'($urandom); mem_to_reg = 1'($urandom);
        end
    endtask

    task automatic put_rand();
        put(($urandom_range(0, 9) < 7), $urandom, 5'($urandom_range(0, 31)),
            1'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom),
            $urandom, $urandom);
    endtask

    // One cycle: check outputs at the falling edge, advance the model at the rising edge.
    task automatic step();
        bit   mv, er, cap, xfer;
        ent_t h, cur;
        @(negedge clk);
        mv = (q.size() > 0);
        h  = mv ? q[0] : last;
        er = SKID ? m_ready : (!mv || mem_ready);
        chk("mem_valid", mem_valid, mv);
        chk("ex_ready", ex_ready, er);
        chk("mem_alu_out", mem_alu_out, h.alu);
        chk("mem_store_data", mem_store_data, h.sd);
        chk("mem_rd", mem_rd, h.rd);
        chk("mem_ctrl", {mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg},
            {h.rw, h.mr, h.mw, h.m2r});
        chk("branch_taken", branch_taken, mv && h.br && h.zf);
        chk("branch_target", branch_target, h.tgt);
        chk("fwd_en", fwd_en, mv && h.rw && (h.rd != 0) && !h.mr);
        chk("fwd_rd", fwd_rd, h.rd);
        chk("fwd_value", fwd_value, h.alu);
        cur = '{alu: alu_out, sd: store_data, tgt: DW'(pc_plus4 + branch_offset), rd: rd,
                zf: alu_zf, rw: reg_write, mr: mem_read, mw: mem_write, m2r: mem_to_reg,
                br: branch};
        cap  = ex_valid && er;
        xfer = mv && mem_ready;
        hold = ex_valid && !er;
        @(posedge clk);
        if (!rst_n) begin
            q.delete();
            last = '0;
        end else begin
            if (xfer) void'(q.pop_front());
            if (flush) q.delete();
            else if (cap) q.push_back(cur);
            if (q.size() > 0) last = q[0];
        end
        m_ready = (q.size() < CAP);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();

        // Simple capture with forwarding
        mem_ready = 1'b0;
        put(1, 32'h5, 5'd3, 1, 0, 0, 0, 32'h100, 32'h0);
        step();
        chk("fwd_value_5", fwd_value, 32'h5);
        chk("fwd_en_5", fwd_en, 1);
        put(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        mem_ready = 1'b1;
        step();

        // Branch target wraps modulo 2^DW
        put(1, 32'h0, 5'd0, 0, 0, 1, 1, 32'hFFFF_FFFC, 32'h8);
        step();
        chk("br_target_wrap", branch_target, 32'h4);
        chk("br_taken_zf1", branch_taken, 1);
        put(1, 32'h0, 5'd0, 0, 0, 1, 0, 32'hFFFF_FFFC, 32'h8);
        step();
        chk("br_taken_zf0", branch_taken, 0);
        put(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();

        // Backpressure: A, B held, C stalls upstream, then drain in order
        mem_ready = 1'b0;
        put(1, 32'hA, 5'd1, 1, 0, 0, 0, 0, 0); step();
        put(1, 32'hB, 5'd2, 1, 0, 0, 0, 0, 0); step();
        put(1, 32'hC, 5'd4, 1, 0, 0, 0, 0, 0); step();
        chk("stall_ready", ex_ready, 1'b0);
        step();
        mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            put(0, 0, 0, 0, 0, 0, 0, 0, 0);
            step();
        end

        // Back-to-back capture and transfer
        for (int i = 0; i < 10; i++) begin
            put(1, 32'(i + 16), 5'd7, 1, 0, 0, 0, 0, 0);
            step();
        end

        // Flush while full with an entry offered
        mem_ready = 1'b0;
        put(1, 32'h11, 5'd5, 1, 0, 0, 0, 0, 0); step();
        put(1, 32'h22, 5'd6, 1, 0, 0, 0, 0, 0); step();
        put(1, 32'h33, 5'd8, 1, 0, 0, 0, 0, 0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_empty", mem_valid, 0);
        hold = 1'b0;
        put(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();

        // Forwarding guards
        mem_ready = 1'b1;
        put(1, 32'h77, 5'd0, 1, 0, 0, 0, 0, 0); step();
        chk("fwd_rd0", fwd_en, 0);
        put(1, 32'h78, 5'd9, 1, 1, 0, 0, 0, 0); step();
        chk("fwd_memread", fwd_en, 0);

        // Mid-stream reset
        put(1, 32'h79, 5'd9, 1, 0, 0, 0, 0, 0);
        mem_ready = 1'b0;
        rst_n = 1'b0;
        step();
        chk("reset_valid", mem_valid, 0);
        rst_n = 1'b1;
        hold = 1'b0;

        // Random traffic with phases of heavy backpressure
        for (int i = 0; i < 3000; i++) begin
            put_rand();
            mem_ready = (((i / 150) % 3) == 0) ? ($urandom_range(0, 4) == 0)
                                                : ($urandom_range(0, 9) < 7);
            flush = ($urandom_range(0, 39) == 0);
            rst_n = !($urandom_range(0, 299) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
